// File: rtl/song_recorder_pkg.sv
// Shared piano parameters: mode encodings, note range and datapath widths
// used by the song recording and playback blocks.
package song_recorder_pkg;

   typedef enum logic [1:0] {
      MODE_STOP  = 2'd0,
      MODE_REC   = 2'd1,
      MODE_PLAY  = 2'd2,
      MODE_PAUSE = 2'd3
   } mode_e;

   localparam int unsigned MAX_NOTE_DEF = 21;
   localparam int unsigned NOTE_W       = 5;
   localparam int unsigned CNT_W        = 6;
   localparam int unsigned LEN_W        = 7;

endpackage

// File: rtl/song_recorder_note_ram.sv
// Single-port take memory: synchronous write, synchronous read-first, no reset.
module note_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned W     = 5,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/song_recorder.sv
// Piano take recorder: records sanitised notes per beat into note_ram and
// plays them back with pause/resume, tracking take length and end of playback.
module song_recorder
   import song_recorder_pkg::*;
#(
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned MAX_NOTE = MAX_NOTE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic              beat_tick,
   input  logic [NOTE_W-1:0] key_note,
   output logic [NOTE_W-1:0] music,
   output logic [CNT_W-1:0]  cnt,
   output logic [LEN_W-1:0]  len,
   output logic              full,
   output logic              done
);

   mode_e             mode_c;
   mode_e             prev_mode_q;
   logic              entering_c;
   logic [NOTE_W-1:0] note_c;
   logic [NOTE_W-1:0] music_q, music_d;
   logic [LEN_W-1:0]  ptr_q, ptr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              done_q, done_d;
   logic              full_q, full_d;
   logic              ram_we_c;
   logic [CNT_W-1:0]  ram_addr_c;
   logic [NOTE_W-1:0] ram_rdata;

   assign mode_c     = mode_e'(mode);
   assign entering_c = (mode_c != prev_mode_q);
   assign note_c     = (key_note > NOTE_W'(MAX_NOTE)) ? '0 : key_note;

   // Pointer is one bit wider than cnt so a full 64-slot take can be told
   // apart from an empty one during playback.
   always_comb begin
      ptr_d    = ptr_q;
      len_d    = len_q;
      done_d   = done_q;
      music_d  = music_q;
      ram_we_c = 1'b0;
      case (mode_c)
         MODE_STOP: begin
            ptr_d   = '0;
            music_d = '0;
            done_d  = 1'b0;
         end
         MODE_REC: begin
            music_d = note_c;
            done_d  = 1'b0;
            if (entering_c) begin
               ptr_d = '0;
               len_d = '0;
            end else if (beat_tick && (len_q < LEN_W'(DEPTH))) begin
               ram_we_c = 1'b1;
               ptr_d    = ptr_q + LEN_W'(1);
               len_d    = len_q + LEN_W'(1);
            end
         end
         MODE_PLAY: begin
            if (entering_c) begin
               music_d = '0;
               if (prev_mode_q != MODE_PAUSE) begin
                  ptr_d  = '0;
                  done_d = 1'b0;
               end
            end else if (beat_tick) begin
               if (ptr_q < len_q) begin
                  music_d = ram_rdata;
                  ptr_d   = ptr_q + LEN_W'(1);
               end else begin
                  music_d = '0;
                  done_d  = 1'b1;
               end
            end
         end
         MODE_PAUSE: begin
            music_d = '0;
         end
      endcase
      full_d = (len_d == LEN_W'(DEPTH));
   end

   // Read address runs one slot ahead so the tick cycle already sees mem[cnt].
   assign ram_addr_c = ram_we_c ? ptr_q[CNT_W-1:0] : ptr_d[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_mode_q <= MODE_STOP;
         music_q     <= '0;
         ptr_q       <= '0;
         len_q       <= '0;
         done_q      <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         prev_mode_q <= mode_c;
         music_q     <= music_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         done_q      <= done_d;
         full_q      <= full_d;
      end
   end

   note_ram #(
      .DEPTH (DEPTH),
      .W     (NOTE_W),
      .AW    (CNT_W)
   ) u_note_ram (
      .clk   (clk),
      .we    (ram_we_c),
      .addr  (ram_addr_c),
      .wdata (note_c),
      .rdata (ram_rdata)
   );

   assign music = music_q;
   assign cnt   = ptr_q[CNT_W-1:0];
   assign len   = len_q;
   assign full  = full_q;
   assign done  = done_q;

endmodule

// File: tb/tb_song_recorder.sv
// Self-checking bench for song_recorder: directed scenarios plus random mode,
// tick and note traffic compared every cycle against a take-level model.
module tb_song_recorder;

   localparam int DEPTH    = 64;
   localparam int MAX_NOTE = 21;
   localparam int ST = 0, RC = 1, PL = 2, PS = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] mode;
   logic       beat_tick;
   logic [4:0] key_note;
   logic [4:0] music;
   logic [5:0] cnt;
   logic [6:0] len;
   logic       full;
   logic       done;

   int vectors = 0;
   int errors  = 0;

   // Model: the take is an array of notes plus how far playback has got.
   int m_take [DEPTH];
   int m_len   = 0;
   int m_pos   = 0;
   int m_music = 0;
   int m_done  = 0;
   int m_prev  = 0;

   song_recorder #(.DEPTH(DEPTH), .MAX_NOTE(MAX_NOTE)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .beat_tick (beat_tick),
      .key_note  (key_note),
      .music     (music),
      .cnt       (cnt),
      .len       (len),
      .full      (full),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  key;
      bit  entering;
      key      = (int'(key_note) > MAX_NOTE) ? 0 : int'(key_note);
      entering = (int'(mode) != m_prev);
      if (!reset) begin
         m_music = 0; m_pos = 0; m_len = 0; m_done = 0; m_prev = ST;
         return;
      end
      case (int'(mode))
         ST: begin m_pos = 0; m_music = 0; m_done = 0; end
         RC: begin
            m_music = key;
            m_done  = 0;
            if (entering) begin m_len = 0; m_pos = 0; end
            else if (beat_tick && m_len < DEPTH) begin
               m_take[m_len] = key;
               m_len++;
               m_pos = m_len;
            end
         end
         PL: begin
            if (entering) begin
               m_music = 0;
               if (m_prev != PS) begin m_pos = 0; m_done = 0; end
            end else if (beat_tick) begin
               if (m_pos < m_len) begin m_music = m_take[m_pos]; m_pos++; end
               else begin m_music = 0; m_done = 1; end
            end
         end
         default: m_music = 0;
      endcase
      m_prev = int'(mode);
   endtask

   task automatic step(input int md, input bit tk, input int key, input bit rst_n = 1'b1);
      mode      = 2'(md);
      beat_tick = tk;
      key_note  = 5'(key);
      reset     = rst_n;
      @(posedge clk);
      model_edge();
      #1;
      check("music", 32'(music), 32'(m_music));
      check("cnt",   32'(cnt),   32'(m_pos % DEPTH));
      check("len",   32'(len),   32'(m_len));
      check("full",  32'(full),  32'(m_len == DEPTH));
      check("done",  32'(done),  32'(m_done));
   endtask

   task automatic play_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(PL, 1'b1, 0);
         step(PL, 1'b0, 0);
      end
   endtask

   initial begin
      int notes [4] = '{13, 14, 0, 8};
      step(ST, 1'b0, 0, 1'b0);
      step(ST, 1'b0, 0, 1'b0);
      check("reset_len", 32'(len), 32'd0);

      // Short take, then full playback past the end.
      step(RC, 1'b0, 0);
      for (int i = 0; i < 4; i++) step(RC, 1'b1, notes[i]);
      step(RC, 1'b0, 0);
      step(PL, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         step(PL, 1'b1, 0);
         check("short_play", 32'(music), 32'(notes[i]));
      end
      step(PL, 1'b1, 0);
      check("short_done", 32'(done), 32'd1);
      check("short_len",  32'(len),  32'd4);

      // Pause after two notes, resume on the third.
      step(ST, 1'b0, 0);
      step(PL, 1'b0, 0);
      play_ticks(2);
      for (int i = 0; i < 10; i++) step(PS, 1'b1, 0);
      check("pause_cnt", 32'(cnt), 32'd2);
      step(PL, 1'b0, 0);
      step(PL, 1'b1, 0);
      check("resume_note", 32'(music), 32'(notes[2]));

      // Out-of-range key is stored as silence.
      step(ST, 1'b0, 0);
      step(RC, 1'b1, 0);
      step(RC, 1'b1, 25);
      step(RC, 1'b1, 9);
      step(ST, 1'b0, 0);
      step(PL, 1'b0, 0);
      play_ticks(3);

      // Overfill the take, then play it all back.
      step(RC, 1'b0, 0);
      for (int i = 0; i < 70; i++) step(RC, 1'b1, $urandom_range(0, 31));
      check("fill_len", 32'(len), 32'd64);
      step(PL, 1'b0, 0);
      play_ticks(66);

      // Empty take, then stop and re-enter play.
      step(RC, 1'b0, 0);
      step(ST, 1'b0, 0);
      step(PL, 1'b0, 0);
      step(PL, 1'b1, 0);
      check("empty_done", 32'(done), 32'd1);
      step(ST, 1'b0, 0);
      step(PL, 1'b0, 0);

      // Reset during playback.
      step(RC, 1'b0, 0);
      for (int i = 0; i < 5; i++) step(RC, 1'b1, i + 3);
      step(PL, 1'b0, 0);
      play_ticks(3);
      step(PL, 1'b1, 0, 1'b0);
      check("rst_len", 32'(len), 32'd0);
      step(PL, 1'b1, 0);

      // Random traffic with occasional resets.
      for (int seg = 0; seg < 150; seg++) begin
         int md  = $urandom_range(0, 3);
         int dur = $urandom_range(1, 40);
         for (int c = 0; c < dur; c++)
            step(md, ($urandom_range(0, 2) == 0), $urandom_range(0, 31),
                 ($urandom_range(0, 199) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
